// File: rtl/dcache_defs.sv
// Shared definitions for the L1 data-cache controller: FSM encoding and
// default geometry (16 sets x 32-byte lines, 32-bit byte addresses).
package dcache_defs;

  localparam int unsigned DEF_NUM_SETS   = 16;
  localparam int unsigned DEF_LINE_BYTES = 32;
  localparam int unsigned DEF_ADDR_W     = 32;

  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned INDEX_W  = 4;
  localparam int unsigned TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W   = DEF_LINE_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data arrays for the direct-mapped cache: asynchronous read,
// synchronous line and word writes, valid/dirty cleared by the async reset.
module dcache_sram #(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned TAG_W    = 23,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned WSEL_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o,
  input  logic              line_we_i,
  input  logic [TAG_W-1:0]  line_tag_i,
  input  logic [LINE_W-1:0] line_data_i,
  input  logic              word_we_i,
  input  logic [WSEL_W-1:0] word_sel_i,
  input  logic [31:0]       word_data_i,
  input  logic              clean_we_i
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = 1'b0;
    end
    if (word_we_i)  dirty_d[idx_i] = 1'b1;
    if (clean_we_i) dirty_d[idx_i] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Contents are don't-care after reset, so the arrays carry no reset.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      data_q[idx_i] <= line_data_i;
      tag_q[idx_i]  <= line_tag_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_sel_i, 5'd0} +: 32] <= word_data_i;
    end
  end

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_data_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller: zero-wait hits,
// pipeline freeze on miss while the victim is written back and the line refilled.
module dcache_controller
  import dcache_defs::*;
#(
  parameter int unsigned NUM_SETS   = DEF_NUM_SETS,
  parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [ADDR_W-1:0]       cpu_addr_i,
  input  logic [31:0]             cpu_wdata_i,
  output logic [31:0]             cpu_rdata_o,
  output logic                    cpu_stall_o,
  output logic                    mem_enable_o,
  output logic                    mem_write_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [LINE_BYTES*8-1:0] mem_data_o,
  input  logic [LINE_BYTES*8-1:0] mem_data_i,
  input  logic                    mem_ack_i
);

  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned LN_W   = LINE_BYTES * 8;
  localparam int unsigned TG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WSEL_W = OFF_W - 2;

  state_e            state_q, state_d;
  logic [TG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;

  logic [TG_W-1:0]   cpu_tag;
  logic [IDX_W-1:0]  cpu_idx, arr_idx;
  logic [WSEL_W-1:0] cpu_word;
  logic              addr_unused;

  logic              rd_valid, rd_dirty, hit;
  logic [TG_W-1:0]   rd_tag;
  logic [LN_W-1:0]   rd_data;
  logic              line_we, word_we, clean_we;

  assign cpu_tag     = cpu_addr_i[ADDR_W-1 -: TG_W];
  assign cpu_idx     = cpu_addr_i[OFF_W +: IDX_W];
  assign cpu_word    = cpu_addr_i[2 +: WSEL_W];
  assign addr_unused = ^cpu_addr_i[1:0];

  // The miss line is latched so a dropped request cannot redirect an in-flight fill.
  assign arr_idx = (state_q == IDLE) ? cpu_idx : miss_idx_q;
  assign hit     = cpu_req_i & rd_valid & (rd_tag == cpu_tag);

  dcache_sram #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TG_W),
    .LINE_W   (LN_W),
    .WSEL_W   (WSEL_W)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (arr_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .line_we_i   (line_we),
    .line_tag_i  (miss_tag_q),
    .line_data_i (mem_data_i),
    .word_we_i   (word_we),
    .word_sel_i  (cpu_word),
    .word_data_i (cpu_wdata_i),
    .clean_we_i  (clean_we)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i && !hit) begin
          miss_tag_d = cpu_tag;
          miss_idx_d = cpu_idx;
          state_d    = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: if (mem_ack_i) state_d = REFILL;
      REFILL:    if (mem_ack_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    clean_we     = 1'b0;
    case (state_q)
      IDLE: word_we = hit & cpu_we_i;
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, miss_idx_q, {OFF_W{1'b0}}};
        mem_data_o   = rd_data;
        clean_we     = mem_ack_i;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        line_we      = mem_ack_i;
      end
      default: ;
    endcase
    // Gated by reset so the pipeline is released as soon as reset asserts.
    cpu_stall_o = rst_i & ((state_q != IDLE) | (cpu_req_i & ~hit));
    cpu_rdata_o = (hit & ~cpu_we_i) ? rd_data[{cpu_word, 5'd0} +: 32] : '0;
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a behavioural line
// memory that acknowledges on the L_MEM-th cycle of each request.
module tb_dcache_controller;

  localparam int L_MEM = 10;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_wdata_i = '0;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i;
  logic         model_ack = 1'b0;
  logic         spur_ack = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  int en_cnt = 0;
  int busy_cycles = 0;
  int txn_no = 0;
  int wb_txn = -1;
  int rd_txn = -1;
  logic [31:0]  last_wb_addr = '0;
  logic [31:0]  last_rd_addr = '0;
  logic [255:0] last_wb_data = '0;
  logic [255:0] wr_lines [int];

  assign mem_ack_i = model_ack | spur_ack;

  always #5 clk_i = ~clk_i;

  dcache_controller #(
    .NUM_SETS   (16),
    .LINE_BYTES (32),
    .ADDR_W     (32)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  // Initial memory image: word w of line l is 0xA000_0000 + l*256 + w; 0x400 word 0 is 0xDEADBEEF.
  function automatic logic [255:0] default_line(input int l);
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = 32'hA000_0000 + 32'(l * 256 + w);
    if (l == 32) v[31:0] = 32'hDEADBEEF;
    return v;
  endfunction

  always @(posedge clk_i) begin
    #1;
    if (!rst_i) begin
      model_ack = 1'b0;
      en_cnt    = 0;
    end else begin
      if (model_ack) begin
        model_ack = 1'b0;
        en_cnt    = 0;
      end
      if (mem_enable_o) begin
        busy_cycles++;
        en_cnt++;
        if (en_cnt == L_MEM) begin
          model_ack = 1'b1;
          txn_no++;
          if (mem_write_o) begin
            wr_lines[int'(mem_addr_o[11:5])] = mem_data_o;
            last_wb_addr = mem_addr_o;
            last_wb_data = mem_data_o;
            wb_txn       = txn_no;
          end else begin
            if (wr_lines.exists(int'(mem_addr_o[11:5])))
              mem_data_i = wr_lines[int'(mem_addr_o[11:5])];
            else
              mem_data_i = default_line(int'(mem_addr_o[11:5]));
            last_rd_addr = mem_addr_o;
            rd_txn       = txn_no;
          end
        end
      end
    end
  end

  // Holds the request until the cycle it completes; cycles counts that final cycle too.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int cycles, output logic [31:0] rdata);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    cycles      = 0;
    do begin
      @(negedge clk_i);
      cycles++;
    end while (cpu_stall_o && cycles < 200);
    rdata = cpu_rdata_o;
    @(posedge clk_i);
    #2;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i      = 1'b0;
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h0000_0400;
    #12;
    n_cmp++; if (cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", cpu_stall_o); end
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", mem_enable_o); end
    n_cmp++; if (mem_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", mem_write_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
    n_cmp++; if (mem_data_o !== 256'h0) begin n_fail++; $display("FAIL reset_mdata: got %h want 0", mem_data_o); end
    n_cmp++; if (cpu_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata_o); end
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_clean_miss();
    int cyc;
    logic [31:0] rd;
    access(1'b0, 32'h0000_0400, 32'h0, cyc, rd);
    n_cmp++; if (cyc !== 1 + L_MEM + 1) begin n_fail++; $display("FAIL clean_miss_cycles: got %0d want %0d", cyc, 1 + L_MEM + 1); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL clean_miss_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (last_rd_addr !== 32'h0000_0400) begin n_fail++; $display("FAIL clean_miss_raddr: got %h want 00000400", last_rd_addr); end
  endtask

  task automatic test_store_hit();
    int cyc, busy0;
    logic [31:0] rd;
    busy0 = busy_cycles;
    access(1'b1, 32'h0000_0404, 32'h1234_5678, cyc, rd);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL store_hit_cycles: got %0d want 1", cyc); end
    access(1'b0, 32'h0000_0404, 32'h0, cyc, rd);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL load_hit_cycles: got %0d want 1", cyc); end
    n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL load_hit_rdata: got %h want 12345678", rd); end
    n_cmp++; if (busy_cycles - busy0 !== 0) begin n_fail++; $display("FAIL hit_mem_traffic: got %0d want 0", busy_cycles - busy0); end
  endtask

  task automatic test_dirty_evict();
    int cyc;
    logic [31:0] rd, w0, w1;
    access(1'b0, 32'h0000_0600, 32'h0, cyc, rd);
    w0 = last_wb_data[31:0];
    w1 = last_wb_data[63:32];
    n_cmp++; if (cyc !== 1 + 2 * L_MEM + 1) begin n_fail++; $display("FAIL dirty_miss_cycles: got %0d want %0d", cyc, 1 + 2 * L_MEM + 1); end
    n_cmp++; if (last_wb_addr !== 32'h0000_0400) begin n_fail++; $display("FAIL evict_wb_addr: got %h want 00000400", last_wb_addr); end
    n_cmp++; if (w1 !== 32'h1234_5678) begin n_fail++; $display("FAIL evict_wb_word1: got %h want 12345678", w1); end
    n_cmp++; if (w0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL evict_wb_word0: got %h want deadbeef", w0); end
    n_cmp++; if (last_rd_addr !== 32'h0000_0600) begin n_fail++; $display("FAIL evict_rd_addr: got %h want 00000600", last_rd_addr); end
    n_cmp++; if (rd_txn !== wb_txn + 1) begin n_fail++; $display("FAIL evict_order: got rd %0d wb %0d want rd = wb+1", rd_txn, wb_txn); end
    n_cmp++; if (rd !== 32'hA000_3000) begin n_fail++; $display("FAIL evict_rdata: got %h want a0003000", rd); end
  endtask

  task automatic test_store_miss();
    int cyc;
    logic [31:0] rd, w0, w1;
    access(1'b1, 32'h0000_0820, 32'hCAFE_F00D, cyc, rd);
    n_cmp++; if (cyc !== 1 + L_MEM + 1) begin n_fail++; $display("FAIL store_miss_cycles: got %0d want %0d", cyc, 1 + L_MEM + 1); end
    n_cmp++; if (last_rd_addr !== 32'h0000_0820) begin n_fail++; $display("FAIL store_miss_raddr: got %h want 00000820", last_rd_addr); end
    access(1'b0, 32'h0000_0820, 32'h0, cyc, rd);
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL store_miss_merged: got %h want cafef00d", rd); end
    access(1'b0, 32'h0000_0824, 32'h0, cyc, rd);
    n_cmp++; if (rd !== 32'hA000_4101) begin n_fail++; $display("FAIL store_miss_refill_w1: got %h want a0004101", rd); end
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL store_miss_resident: got %0d want 1", cyc); end
    // Evicting the line through an alias shows whether the merged store left it dirty.
    access(1'b0, 32'h0000_0A20, 32'h0, cyc, rd);
    w0 = last_wb_data[31:0];
    w1 = last_wb_data[63:32];
    n_cmp++; if (cyc !== 1 + 2 * L_MEM + 1) begin n_fail++; $display("FAIL alias_dirty_cycles: got %0d want %0d", cyc, 1 + 2 * L_MEM + 1); end
    n_cmp++; if (last_wb_addr !== 32'h0000_0820) begin n_fail++; $display("FAIL alias_wb_addr: got %h want 00000820", last_wb_addr); end
    n_cmp++; if (w0 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL alias_wb_word0: got %h want cafef00d", w0); end
    n_cmp++; if (w1 !== 32'hA000_4101) begin n_fail++; $display("FAIL alias_wb_word1: got %h want a0004101", w1); end
    n_cmp++; if (rd !== 32'hA000_5100) begin n_fail++; $display("FAIL alias_rdata: got %h want a0005100", rd); end
  endtask

  task automatic test_spurious_ack_and_drop();
    int cyc, busy0, n;
    logic [31:0] rd;
    busy0    = busy_cycles;
    spur_ack = 1'b1;
    @(posedge clk_i);
    #2;
    spur_ack = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL spur_ack_enable: got %b want 0", mem_enable_o); end
    n_cmp++; if (busy_cycles - busy0 !== 0) begin n_fail++; $display("FAIL spur_ack_traffic: got %0d want 0", busy_cycles - busy0); end
    access(1'b0, 32'h0000_0600, 32'h0, cyc, rd);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL spur_ack_hit: got %0d want 1", cyc); end

    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0C40;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!mem_enable_o && n < 5);
    n_cmp++; if (mem_enable_o !== 1'b1) begin n_fail++; $display("FAIL drop_req_enable: got %b want 1", mem_enable_o); end
    repeat (3) @(posedge clk_i);
    #2;
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL drop_req_stall_held: got %b want 1", cpu_stall_o); end
    n_cmp++; if (mem_addr_o !== 32'h0000_0C40) begin n_fail++; $display("FAIL drop_req_addr: got %h want 00000c40", mem_addr_o); end
    n = 0;
    do begin @(negedge clk_i); n++; end while (mem_enable_o && n < 3 * L_MEM);
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL drop_req_complete: got %b want 0", mem_enable_o); end
    n_cmp++; if (cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL drop_req_stall_end: got %b want 0", cpu_stall_o); end
    @(posedge clk_i);
    #2;
    access(1'b0, 32'h0000_0C40, 32'h0, cyc, rd);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL drop_req_installed: got %0d want 1", cyc); end
    n_cmp++; if (rd !== 32'hA000_6200) begin n_fail++; $display("FAIL drop_req_rdata: got %h want a0006200", rd); end
  endtask

  task automatic test_reset_mid_refill();
    int cyc, n;
    logic [31:0] rd;
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0E60;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!mem_enable_o && n < 5);
    n_cmp++; if (mem_enable_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_started: got %b want 1", mem_enable_o); end
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_enable: got %b want 0", mem_enable_o); end
    n_cmp++; if (cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall: got %b want 0", cpu_stall_o); end
    @(posedge clk_i);
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #2;
    access(1'b0, 32'h0000_0600, 32'h0, cyc, rd);
    n_cmp++; if (cyc !== 1 + L_MEM + 1) begin n_fail++; $display("FAIL mid_rst_invalidated: got %0d want %0d", cyc, 1 + L_MEM + 1); end
    n_cmp++; if (rd !== 32'hA000_3000) begin n_fail++; $display("FAIL mid_rst_rdata: got %h want a0003000", rd); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_store_hit();
    test_dirty_evict();
    test_store_miss();
    test_spurious_ack_and_drop();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data-cache controller. Sits between the MEM pipeline stage and the off-chip data memory.
- Serves CPU hits with zero-wait combinational read data. On a miss it freezes the whole pipeline and sequences victim write-back and line refill over a req/ack memory port.
- Its stall output is OR-ed with the load-use stall by the top-level pipeline.

Parameters:
- NUM_SETS, 16, number of cache lines (power of 2); INDEX_W = log2(NUM_SETS).
- LINE_BYTES, 32, bytes per line; OFFSET_W = 5, LINE_W = 256.
- ADDR_W, 32, byte-address width; TAG_W = ADDR_W - INDEX_W - OFFSET_W (23 at defaults).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- cpu_req_i  in  1  MEM-stage access valid (MemRead | MemWrite)
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  byte address, word aligned
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data; valid when cpu_req_i & !cpu_we_i & !cpu_stall_o
- cpu_stall_o  out  1  freeze PC and all pipeline registers
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1 = line write-back, 0 = line read
- mem_addr_o  out  ADDR_W  line-aligned address (low OFFSET_W bits zero)
- mem_data_o  out  LINE_W  victim line for write-back
- mem_data_i  in  LINE_W  refill line
- mem_ack_i  in  1  single-cycle completion pulse

Behaviour:
- Address split: tag = addr[ADDR_W-1:9], index = addr[8:5], word = addr[4:2]; addr[1:0] ignored.
- Per line: valid, dirty, tag, LINE_W data.
- Reset (async, rst_i low):
  - All valid and dirty bits clear; state = IDLE.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, cpu_rdata_o = 0.
  - cpu_stall_o = 0; data/tag contents are don't-care.
- hit = cpu_req_i & valid[index] & (tag[index] == tag), evaluated combinationally every cycle.
- States: IDLE, WRITEBACK, REFILL.
- IDLE:
  - Read hit: cpu_rdata_o = data[index][word*32 +: 32], stall 0, no state change.
  - Write hit: stall 0; at the clock edge the word is replaced with cpu_wdata_i and dirty[index] is set.
  - Miss (cpu_req_i & !hit): cpu_stall_o = 1 in the same cycle.
    - If valid & dirty: next state WRITEBACK.
    - Otherwise: next state REFILL.
  - No req: stall 0, idle.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line.
  - On mem_ack_i, next state REFILL and dirty[index] clears.
- REFILL:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {cpu tag, index, 5'b0}.
  - On mem_ack_i: data = mem_data_i, tag written, valid = 1, dirty = 0; next state IDLE.
- Stall rule: cpu_stall_o = (state != IDLE) | (cpu_req_i & !hit).
  - After a refill, the next IDLE cycle re-evaluates the held request as a hit.
  - Stores merge on that cycle, so stored data is never written into a line before refill.
- Latency:
  - Hit: 0 extra cycles.
  - Clean miss: 1 + L_mem + 1 cycles of stall, where L_mem counts cycles from mem_enable_o to ack inclusive.
  - Dirty miss: 1 + 2·L_mem + 1.
- Memory outputs are decoded from state only. They are stable while mem_enable_o is high and deassert in the cycle after ack.
- mem_ack_i in IDLE is ignored.
- CPU holds cpu_req_i, cpu_addr_i, cpu_we_i and cpu_wdata_i stable while stalled. If cpu_req_i drops mid-miss, the in-flight memory transaction still completes and the line is installed. No abort.
- Reset asserted mid-transaction: mem_enable_o drops immediately and the cache is invalidated. The memory model must tolerate an abandoned request.
- Index wrap/alias: two addresses with the same index and different tags evict each other. There is no partial-line state.

Decomposition:
- Shared include/package `dcache_defs`:
  - state encodings IDLE=2'd0, WRITEBACK=2'd1, REFILL=2'd2
  - OFFSET_W, INDEX_W, TAG_W, LINE_W
  - field-slice macros for tag, index and word
- One sub-module, `dcache_sram`: tag/valid/dirty/data arrays.
  - Async read.
  - Synchronous write with a line-write port and a word-write port.
  - Async clear of valid/dirty on rst_i.
- The controller holds the FSM, hit logic and memory port.

Test Plan:
- Reset then load 0x0000_0400 (memory holds 0xDEADBEEF), L_mem = 10:
  - stall high for 12 cycles, one read request to 0x400;
  - then rdata = 0xDEADBEEF, stall low.
- Store 0x12345678 to 0x404 after the line is resident:
  - no stall;
  - a subsequent load of 0x404 returns 0x12345678 with zero stall and no memory traffic.
- Dirty eviction: load 0x0000_0600 (same index 0, new tag):
  - write-back of the 0x400 line with word 1 = 0x12345678 to address 0x400;
  - then refill from 0x600;
  - stall = 22 cycles.
- Store miss to 0x0000_0820:
  - refill first, then the word merges;
  - dirty set;
  - mem_data_i word 0 is replaced only after the refill.
- Spurious mem_ack_i in IDLE plus cpu_req_i dropped mid-refill:
  - ack is ignored;
  - the refill completes and the line becomes valid;
  - stall drops once the FSM returns to IDLE.
- rst_i pulsed low during REFILL:
  - mem_enable_o = 0 and cpu_stall_o = 0 asynchronously;
  - a previously resident address misses after release.
